muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Owns the architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage. Accepts one operation at a time and runs an iterative 32-step shift-add multiply or restoring divide.
- Asserts busy so the pipeline stalls any MFHI/MFLO or new mul/div op until the result is committed.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_iter.sv | 60 ++++++
 rtl/muldiv_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the multi-cycle multiply/divide
//               sequencer: operation encoding, FSM state type, default
//               datapath width and the divide-by-zero quotient fill value.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // Operation encoding driven by the decode stage.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Quotient returned on divide by zero; sliced down to WIDTH (WIDTH <= 64).
    localparam logic [63:0] DIVZ_LO = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply : shift-add on {acc, shr}; shr holds the multiplier
//                          and is consumed from the LSB.
//               Divide   : restoring shift-subtract; acc is the partial
//                          remainder, shr holds the dividend and collects
//                          quotient bits from the LSB.
// Ports       : is_div  - 1 selects divide step, 0 selects multiply step
//               acc_in  - upper working register (WIDTH+1 bits)
//               shr_in  - lower working register (WIDTH bits)
//               opnd    - multiplicand or divisor magnitude
//               acc_out - next upper working register
//               shr_out - next lower working register
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] shr_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] shr_out
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;

    // Multiply: add the multiplicand when the current multiplier bit is set.
    // acc_in[WIDTH] is always 0 entering a step, so WIDTH+1 bits cannot wrap.
    assign w_sum = shr_in[0] ? (acc_in + {1'b0, opnd}) : acc_in;

    // Divide: bring the next dividend bit into the partial remainder and
    // trial-subtract; the extra top bit of w_diff is the borrow.
    assign w_shifted = {acc_in[WIDTH-1:0], shr_in[WIDTH-1]};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, opnd};

    always_comb begin
        acc_out = '0;
        shr_out = '0;
        if (is_div) begin
            if (w_diff[WIDTH+1]) begin
                acc_out = w_shifted;
                shr_out = {shr_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = w_diff[WIDTH:0];
                shr_out = {shr_in[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_out = {1'b0, w_sum[WIDTH:1]};
            shr_out = {w_sum[0], shr_in[WIDTH-1:1]};
        end
    end

endmodule : muldiv_iter
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//               Owns the architectural HI/LO registers. A mul/div runs on
//               operand magnitudes for WIDTH iterations, then a FIX cycle
//               applies sign correction and commits HI/LO.
// Ports       : clk    - rising-edge clock
//               reset  - synchronous active-high reset
//               start  - request, sampled only in IDLE
//               op     - operation code (muldiv_pkg OP_*)
//               a      - rs operand: dividend / multiplicand / MTHI-MTLO data
//               b      - rt operand: divisor / multiplier
//               cancel - exception flush; aborts an in-flight mul/div
//               busy   - high whenever the FSM is not IDLE
//               done   - one-cycle pulse after HI/LO commit by a mul/div
//               hi, lo - HI/LO registers, read directly by MFHI/MFLO
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_shr;
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_a_orig;
    logic                 r_is_div;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic                 r_div_zero;

    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_idle_req;
    logic                 w_is_md;
    logic                 w_accept;
    logic                 w_commit;
    logic                 w_signed;
    logic                 w_op_div;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    logic [WIDTH:0]       w_acc_nxt;
    logic [WIDTH-1:0]     w_shr_nxt;

    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_hi_res;
    logic [WIDTH-1:0]     w_lo_res;

    // ------------------------------------------------------------------------
    // Request decode. cancel in IDLE suppresses any same-cycle start.
    // ------------------------------------------------------------------------
    assign w_idle_req = (r_state == ST_IDLE) && start && !cancel;
    assign w_is_md    = (op[2] == 1'b0);           // MULT/MULTU/DIV/DIVU
    assign w_accept   = w_idle_req && w_is_md;
    assign w_signed   = !op[0];                    // MULT and DIV are even codes
    assign w_op_div   = op[1];

    // Negating the most negative value yields itself, which read as unsigned
    // is the correct magnitude 2^(WIDTH-1).
    assign w_a_mag = (w_signed && a[WIDTH-1]) ? (-a) : a;
    assign w_b_mag = (w_signed && b[WIDTH-1]) ? (-b) : b;

    assign w_commit = (r_state == ST_FIX) && !cancel;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Single-iteration datapath
    // ------------------------------------------------------------------------
    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .is_div  (r_is_div),
        .acc_in  (r_acc),
        .shr_in  (r_shr),
        .opnd    (r_opnd),
        .acc_out (w_acc_nxt),
        .shr_out (w_shr_nxt)
    );

    // ------------------------------------------------------------------------
    // Sign correction and result selection for the FIX commit.
    // Divide by zero bypasses sign correction: LO is all ones and HI is the
    // original (uncorrected) dividend.
    // ------------------------------------------------------------------------
    assign w_prod     = {r_acc[WIDTH-1:0], r_shr};
    assign w_prod_fix = r_neg_res ? (-w_prod) : w_prod;
    assign w_quo_fix  = r_neg_res ? (-r_shr) : r_shr;
    assign w_rem_fix  = r_neg_rem ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];

    always_comb begin
        w_hi_res = '0;
        w_lo_res = '0;
        if (!r_is_div) begin
            w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
            w_lo_res = w_prod_fix[WIDTH-1:0];
        end else if (r_div_zero) begin
            w_hi_res = r_a_orig;
            w_lo_res = DIVZ_LO[WIDTH-1:0];
        end else begin
            w_hi_res = w_rem_fix;
            w_lo_res = w_quo_fix;
        end
    end

    // ------------------------------------------------------------------------
    // Working registers, counter, HI/LO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_shr      <= '0;
            r_opnd     <= '0;
            r_a_orig   <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_commit;

            if (w_idle_req && (op == OP_MTHI)) begin
                r_hi <= a;
            end
            if (w_idle_req && (op == OP_MTLO)) begin
                r_lo <= a;
            end

            if (w_accept) begin
                r_cnt      <= '0;
                r_acc      <= '0;
                r_is_div   <= w_op_div;
                r_a_orig   <= a;
                r_div_zero <= w_op_div && (b == '0);
                r_neg_res  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_rem  <= w_signed && w_op_div && a[WIDTH-1];
                // The lower register is consumed/shifted: dividend or multiplier.
                r_shr      <= w_op_div ? w_a_mag : w_b_mag;
                r_opnd     <= w_op_div ? w_b_mag : w_a_mag;
            end else if ((r_state == ST_CALC) && !cancel) begin
                r_acc <= w_acc_nxt;
                r_shr <= w_shr_nxt;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_commit) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : muldiv_ctrl
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl: table of directed
//               mul/div vectors plus hand-written MTHI/MTLO, cancel, reset
//               and invalid-op sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int c_nvec = 13;
    vec_t tbl [c_nvec];

    muldiv_ctrl #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Issue one mul/div at a negedge (start cycle = cycle 0) and watch up to
    // 60 following cycles for done, counting busy cycles and checking that
    // HI/LO hold while the operation runs.
    task automatic run_md(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          output int lat, output int bcnt, output bit held);
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        hi0   = hi;
        lo0   = lo;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        lat   = 0;
        bcnt  = 0;
        held  = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if ((n <= 33) && ((hi !== hi0) || (lo !== lo0))) held = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        int  bcnt;
        bit  held;
        bit  saw_busy;
        bit  saw_done;
        logic [31:0] lo_keep;

        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        cancel = 1'b0;

        tbl[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{OP_DIVU,  32'd100,      32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        tbl[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5]  = '{OP_DIVU,  32'd9,        32'd2,        32'd1,        32'd4};
        tbl[6]  = '{OP_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};
        tbl[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        tbl[10] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        tbl[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        tbl[12] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);

        // Table-driven mul/div vectors.
        for (int i = 0; i < c_nvec; i++) begin
            run_md(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcnt, held);
            check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, tbl[i].exp_hi});
            check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, tbl[i].exp_lo});
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd33);
            check($sformatf("v%0d_hold", i), {63'd0, held}, 64'd1);
        end

        // MTLO while idle.
        @(negedge clk);
        start = 1'b1; op = OP_MTLO; a = 32'hCAFEBABE;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'h00000000CAFEBABE);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        check("mtlo_done", {63'd0, done}, 64'd0);

        // cancel in IDLE blocks a same-cycle start.
        start = 1'b1; op = OP_MTLO; a = 32'h12345678; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("idle_cancel_lo", {32'd0, lo}, 64'h00000000CAFEBABE);
        check("idle_cancel_busy", {63'd0, busy}, 64'd0);

        // Invalid op is ignored.
        start = 1'b1; op = 3'd6; a = 32'h55555555; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("badop_busy", {63'd0, busy}, 64'd0);
        check("badop_lo", {32'd0, lo}, 64'h00000000CAFEBABE);

        // MTHI preload, then DIVU 9/2 with a second start at cycle 5 and
        // cancel at cycle 10.
        start = 1'b1; op = OP_MTHI; a = 32'h11111111;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'h0000000011111111);
        lo_keep = lo;
        start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;        // cycle 0
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start  = (n == 5);
            cancel = (n == 10);
            if (n == 5) begin
                op = OP_MULTU; a = 32'd3; b = 32'd3;
            end
        end
        check("cancel_busy_c10", {63'd0, busy}, 64'd1);
        saw_busy = 1'b0;
        saw_done = 1'b0;
        for (int n = 11; n <= 50; n++) begin
            @(negedge clk);
            start  = 1'b0;
            cancel = 1'b0;
            if (busy) saw_busy = 1'b1;
            if (done) saw_done = 1'b1;
        end
        check("cancel_busy_after", {63'd0, saw_busy}, 64'd0);
        check("cancel_no_done", {63'd0, saw_done}, 64'd0);
        check("cancel_hi", {32'd0, hi}, 64'h0000000011111111);
        check("cancel_lo", {32'd0, lo}, {32'd0, lo_keep});

        // Reset in the middle of a multiply.
        start = 1'b1; op = OP_MULTU; a = 32'hFFFF; b = 32'hFFFF;  // cycle 0
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            reset = (n == 20);
        end
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_hi", {32'd0, hi}, 64'd0);
        check("midreset_lo", {32'd0, lo}, 64'd0);
        check("midreset_done", {63'd0, done}, 64'd0);
        run_md(OP_MULTU, 32'd6, 32'd7, lat, bcnt, held);
        check("post_reset_hi", {32'd0, hi}, 64'd0);
        check("post_reset_lo", {32'd0, lo}, 64'd42);
        check("post_reset_latency", 64'(lat), 64'd34);

        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_muldiv_ctrl
`default_nettype wire
